pll_lock_sequencer: RTL and testbench

//   Control-side counterpart of the alta_pllx PLL wrapper. Drives the PLL's pllen,

---
 rtl/pll_lock_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: timed PLL reset, lock qualification, clock-output gating and retry.
// Define PLL_SEQ_AUTORELOCK_EN to restart bring-up on loss of lock in RUN instead of failing.
module pll_lock_sequencer #(
  parameter int         RESET_CYCLES        = 16,
  parameter int         LOCK_STABLE_CYCLES  = 64,
  parameter int         LOCK_TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRIES         = 3,
  parameter logic [3:0] CLKOUT_EN_MASK      = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       lock_in,
  output logic       pllen,
  output logic       pll_resetn,
  output logic [3:0] clkout_en,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int RW = $clog2(RESET_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STB_DONE = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);

  // retry_cnt saturates at 3, so a larger retry limit behaves like 3.
  localparam int         MAXR_CLAMP = (MAX_RETRIES > 3) ? 3 : MAX_RETRIES;
  localparam logic [1:0] MAX_R      = 2'(MAXR_CLAMP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [1:0]    retry_cnt_q, retry_cnt_d;

  logic          pllen_q, pllen_d;
  logic          pll_resetn_q, pll_resetn_d;
  logic [3:0]    clkout_en_q, clkout_en_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  logic          timeout_hit;
  logic [1:0]    retry_inc;
  logic          retry_exhausted;

  always_comb begin
    lock_meta_d     = lock_in;
    lock_s_d        = lock_meta_q;

    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    stable_cnt_d    = stable_cnt_q;
    timeout_cnt_d   = timeout_cnt_q;
    retry_cnt_d     = retry_cnt_q;

    timeout_hit     = (timeout_cnt_q == TO_LAST);
    retry_inc       = (retry_cnt_q == 2'd3) ? 2'd3 : retry_cnt_q + 2'd1;
    retry_exhausted = (retry_inc >= MAX_R);

    if (!enable) begin
      // retry_cnt is deliberately held so software can read why bring-up stopped.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          retry_cnt_d = '0;
        end

        ST_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d       = ST_WAIT_LOCK;
            timeout_cnt_d = '0;
            stable_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end

        ST_WAIT_LOCK: begin
          timeout_cnt_d = timeout_hit ? timeout_cnt_q : timeout_cnt_q + TW'(1);
          if (timeout_hit) begin
            retry_cnt_d = retry_inc;
            rst_cnt_d   = '0;
            state_d     = retry_exhausted ? ST_FAIL : ST_RESET;
          end else if (lock_s_q) begin
            state_d      = ST_STABLE;
            stable_cnt_d = SW'(1);
          end
        end

        ST_STABLE: begin
          timeout_cnt_d = timeout_hit ? timeout_cnt_q : timeout_cnt_q + TW'(1);
          // A completed stability window beats a simultaneous timeout.
          if (stable_cnt_q >= STB_DONE) begin
            state_d = ST_RUN;
          end else if (timeout_hit) begin
            retry_cnt_d = retry_inc;
            rst_cnt_d   = '0;
            state_d     = retry_exhausted ? ST_FAIL : ST_RESET;
          end else if (lock_s_q) begin
            stable_cnt_d = stable_cnt_q + SW'(1);
          end else begin
            state_d      = ST_WAIT_LOCK;
            stable_cnt_d = '0;
          end
        end

        ST_RUN: begin
          if (!lock_s_q) begin
`ifdef PLL_SEQ_AUTORELOCK_EN
            state_d     = ST_RESET;
            rst_cnt_d   = '0;
            retry_cnt_d = '0;
`else
            state_d     = ST_FAIL;
`endif
          end
        end

        ST_FAIL: begin
          state_d = ST_FAIL;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    pllen_d      = 1'b0;
    pll_resetn_d = 1'b0;
    clkout_en_d  = 4'b0000;
    ready_d      = 1'b0;
    fail_d       = 1'b0;
    case (state_d)
      ST_RESET: begin
        pllen_d = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pllen_d      = 1'b1;
        pll_resetn_d = 1'b1;
      end
      ST_RUN: begin
        pllen_d      = 1'b1;
        pll_resetn_d = 1'b1;
        clkout_en_d  = CLKOUT_EN_MASK;
        ready_d      = 1'b1;
      end
      ST_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        pllen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      rst_cnt_q     <= '0;
      stable_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      retry_cnt_q   <= '0;
      pllen_q       <= 1'b0;
      pll_resetn_q  <= 1'b0;
      clkout_en_q   <= 4'b0000;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_meta_q   <= lock_meta_d;
      lock_s_q      <= lock_s_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      pllen_q       <= pllen_d;
      pll_resetn_q  <= pll_resetn_d;
      clkout_en_q   <= clkout_en_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign pllen      = pllen_q;
  assign pll_resetn = pll_resetn_q;
  assign clkout_en  = clkout_en_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized lock_in episodes checked against a timeline model
// derived from lock-run lengths, attempt windows and retry rules.
module tb_pll_lock_sequencer;

  localparam int         RC   = 4;
  localparam int         SC   = 8;
  localparam int         TC   = 64;
  localparam int         MR   = 2;
  localparam logic [3:0] MASK = 4'b0101;
  localparam int         MAXL = 260;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       lock_in;
  logic       pllen;
  logic       pll_resetn;
  logic [3:0] clkout_en;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;

  pll_lock_sequencer #(
    .RESET_CYCLES       (RC),
    .LOCK_STABLE_CYCLES (SC),
    .LOCK_TIMEOUT_CYCLES(TC),
    .MAX_RETRIES        (MR),
    .CLKOUT_EN_MASK     (MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .lock_in   (lock_in),
    .pllen     (pllen),
    .pll_resetn(pll_resetn),
    .clkout_en (clkout_en),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ep_idx   = 0;
  int         m_retry  = 0;
  bit         li[0:MAXL];
  bit         ls[0:MAXL];
  logic [9:0] exp_w[0:MAXL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pllen, pll_resetn, clkout_en, ready, fail, retry_cnt}
  function automatic logic [9:0] mk(input bit pe, input bit rn, input logic [3:0] ce,
                                    input bit rd, input bit fl, input int rc);
    return {pe, rn, ce, rd, fl, 2'(rc)};
  endfunction

  function automatic logic [9:0] obs();
    return {pllen, pll_resetn, clkout_en, ready, fail, retry_cnt};
  endfunction

  // Expected outputs for cycles 0..L of an episode; enable is raised in cycle 0.
  task automatic predict(input int L);
    int  t, tw, c, run, d, retry;
    bit  done;
    for (int k = 0; k <= L; k++) ls[k] = (k >= 2) ? li[k-2] : 1'b0;
    for (int k = 0; k <= L; k++) exp_w[k] = mk(0, 0, 4'b0, 0, 0, m_retry);
    retry = 0;
    t     = 1;
    done  = 1'b0;
    while (!done && t <= L) begin
      for (int i = 0; i < RC; i++) if (t + i <= L) exp_w[t+i] = mk(1, 0, 4'b0, 0, 0, retry);
      tw  = t + RC;
      c   = -1;
      run = 0;
      // RUN starts two cycles after the SC-th consecutive synced-high cycle in the window.
      for (int j = tw; j <= tw + TC - 2 && j <= L; j++) begin
        run = ls[j] ? run + 1 : 0;
        if (run == SC) begin
          c = j + 2;
          break;
        end
      end
      if (c < 0) begin
        for (int j = tw; j < tw + TC; j++) if (j <= L) exp_w[j] = mk(1, 1, 4'b0, 0, 0, retry);
        retry = (retry == 3) ? 3 : retry + 1;
        if (retry < MR) begin
          t = tw + TC;
        end else begin
          for (int j = tw + TC; j <= L; j++) exp_w[j] = mk(0, 0, 4'b0, 0, 1, retry);
          done = 1'b1;
        end
      end else begin
        for (int j = tw; j < c; j++) if (j <= L) exp_w[j] = mk(1, 1, 4'b0, 0, 0, retry);
        d = c;
        while (d <= L && ls[d]) begin
          exp_w[d] = mk(1, 1, MASK, 1, 0, retry);
          d++;
        end
        if (d > L) begin
          done = 1'b1;
        end else begin
          exp_w[d] = mk(1, 1, MASK, 1, 0, retry);
`ifdef PLL_SEQ_AUTORELOCK_EN
          retry = 0;
          t     = d + 1;
`else
          for (int j = d + 1; j <= L; j++) exp_w[j] = mk(0, 0, 4'b0, 0, 1, retry);
          done = 1'b1;
`endif
        end
      end
    end
  endtask

  // kind: 0 clean lock, 1 glitch, 2 never, 3 loss after lock, 4 random toggling
  task automatic gen_lock(input int kind, input int r, input int L);
    bit cur;
    int q, ql;
    q   = r + SC + 3 + $urandom_range(0, 20);
    ql  = $urandom_range(1, 20);
    cur = 1'($urandom_range(0, 1));
    for (int k = 0; k <= L; k++) begin
      case (kind)
        0:       li[k] = (k >= r);
        1:       li[k] = (k >= r) && (k != r + 5);
        2:       li[k] = 1'b0;
        3:       li[k] = (k >= r) && !(k >= q && k < q + ql);
        default: begin
          if ($urandom_range(0, 11) == 0) cur = !cur;
          li[k] = cur;
        end
      endcase
    end
  endtask

  task automatic run_episode(input int kind, input int r, input int L, input bit use_rst,
                             input int gap);
    gen_lock(kind, r, L);
    predict(L);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      check_eq($sformatf("ep%0d_cyc%0d", ep_idx, k), 32'(obs()), 32'(exp_w[k]));
      lock_in = li[k];
      if (k < L) begin
        rst    = 1'b0;
        enable = 1'b1;
      end else if (use_rst) begin
        rst    = 1'b1;
      end else begin
        enable = 1'b0;
      end
    end
    m_retry = use_rst ? 0 : int'(exp_w[L][1:0]);
    $display("episode %0d kind=%0d lock_rise=%0d len=%0d abort=%s gap=%0d retry_after=%0d",
             ep_idx, kind, r, L, use_rst ? "rst" : "enable", gap, m_retry);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_eq($sformatf("ep%0d_gap%0d", ep_idx, g), 32'(obs()), 32'(mk(0, 0, 4'b0, 0, 0, m_retry)));
      rst     = 1'b0;
      enable  = 1'b0;
      lock_in = 1'b0;
    end
    ep_idx++;
  endtask

  initial begin
    int kind, r, L;
    rst     = 1'b1;
    enable  = 1'b0;
    lock_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("reset_cyc%0d", i), 32'(obs()), 32'(10'd0));
    end
    rst     = 1'b0;
    m_retry = 0;

    // Directed episodes: nominal, glitch, no lock to FAIL, recovery, loss in RUN,
    // rst during STABLE, enable drop in RUN.
    run_episode(0, 10, 40,  1'b0, 2);
    run_episode(1, 10, 45,  1'b0, 1);
    run_episode(2, 0,  150, 1'b0, 0);
    run_episode(0, 12, 40,  1'b0, 1);
    run_episode(3, 10, 90,  1'b0, 2);
    run_episode(0, 10, 16,  1'b1, 2);
    run_episode(0, 10, 30,  1'b0, 1);

    for (int e = 0; e < 30; e++) begin
      kind = $urandom_range(0, 4);
      r    = $urandom_range(4, 70);
      L    = (kind == 2) ? $urandom_range(100, 200) : $urandom_range(20, 200);
      run_episode(kind, r, L, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
